button_debouncer: RTL and testbench

- Input-side companion to the LED blinker.
- Takes one raw, asynchronous, bouncing pushbutton pin (e.g. Alhambra II SW1/SW2) and produces a clean debounced level.
- Also produces single-cycle press, release and long-press event pulses, plus a toggle level that can drive an LED directly.
- Instantiated once per button at top level, clocked by the 12 MHz board clock.

---
 rtl/button_debouncer.sv | 154 +++++++++++++++
 tb/tb_button_debouncer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronizes a raw bouncing pin, accepts a level
// change only after N consecutive agreeing samples, and derives press,
// release, long-press pulses and a toggle level from the accepted level.
module button_debouncer #(
  parameter int N          = 120000,
  parameter int L          = 12000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic TOGGLE
);

  localparam int CW = $clog2(N);
  localparam int HW = $clog2(L);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [HW-1:0] HELD_LAST = HW'(L - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } state_t;

  logic          sync1, sync2;
  logic          s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] held, held_n;
  logic          long_done, long_done_n;
  logic          level_n, press_n, release_n, long_n, toggle_n;

  // Two-flop synchronizer; resets to the idle pin level so no false press follows reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their inputs
      // from before the edge; blocking here would collapse the chain to one flop.
      sync1 <= BTN;
      sync2 <= sync1;
    end
  end

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign s = sync2 ^ ACTIVE_LOW;

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= RELEASED;
      cnt       <= '0;
      held      <= '0;
      long_done <= 1'b0;
      LEVEL     <= 1'b0;
      PRESS     <= 1'b0;
      RELEASE   <= 1'b0;
      LONG      <= 1'b0;
      TOGGLE    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      held      <= held_n;
      long_done <= long_done_n;
      LEVEL     <= level_n;
      PRESS     <= press_n;
      RELEASE   <= release_n;
      LONG      <= long_n;
      TOGGLE    <= toggle_n;
    end
  end

  // Next-state logic: debounce FSM plus long-press hold timer.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_n     = state;
    cnt_n       = cnt;
    held_n      = held;
    long_done_n = long_done;
    level_n     = LEVEL;
    toggle_n    = TOGGLE;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;

    unique case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_CHK;
          cnt_n   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n     = PRESSED;
          level_n     = 1'b1;
          press_n     = 1'b1;
          toggle_n    = ~TOGGLE;
          held_n      = '0;
          long_done_n = 1'b0;
          cnt_n       = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = REL_CHK;
          cnt_n   = CW'(1);
        end
      end
      REL_CHK: begin
        if (s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = RELEASED;
          level_n   = 1'b0;
          release_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase

    // Hold timer runs while the button counts as down; a release on the
    // same edge takes precedence over the long-press pulse.
    if ((state == PRESSED || state == REL_CHK) && !release_n) begin
      if (held != HELD_LAST) begin
        held_n = held + 1'b1;
      end else if (!long_done) begin
        long_n      = 1'b1;
        long_done_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (active-high pin and inverted
// active-low pin) are compared every cycle against a run-length model,
// and directed scenarios pin exact event edges with literal expectations.
module tb_button_debouncer;

  localparam int N = 4;
  localparam int L = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;

  logic h_level, h_press, h_release, h_long, h_toggle;
  logic l_level, l_press, l_release, l_long, l_toggle;

  int total = 0;
  int bad   = 0;
  int press_cnt = 0, release_cnt = 0, long_cnt = 0;

  button_debouncer #(.N(N), .L(L), .ACTIVE_LOW(1'b0)) dut_h (
    .CLK(clk), .RSTN(rst_n), .BTN(btn),
    .LEVEL(h_level), .PRESS(h_press), .RELEASE(h_release), .LONG(h_long), .TOGGLE(h_toggle)
  );

  button_debouncer #(.N(N), .L(L), .ACTIVE_LOW(1'b1)) dut_l (
    .CLK(clk), .RSTN(rst_n), .BTN(~btn),
    .LEVEL(l_level), .PRESS(l_press), .RELEASE(l_release), .LONG(l_long), .TOGGLE(l_toggle)
  );

  always #5 clk = ~clk;

  // Output vectors ordered {LEVEL, PRESS, RELEASE, LONG, TOGGLE}.
  wire [4:0] oh = {h_level, h_press, h_release, h_long, h_toggle};
  wire [4:0] ol = {l_level, l_press, l_release, l_long, l_toggle};

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted level flips once the sample has disagreed with it for N
  // consecutive edges; LONG fires on the L-th edge after the press edge
  // if the button is still accepted as down and no release lands then.
  bit m_d1, m_d2;
  bit m_lvl, m_prs, m_rls, m_lng, m_tgl, m_ldone;
  int m_run, m_since;
  bit n_lvl, n_prs, n_rls, n_lng, n_tgl, n_ldone;
  int n_run, n_since;

  always_comb begin
    n_lvl   = m_lvl;
    n_tgl   = m_tgl;
    n_ldone = m_ldone;
    n_since = m_since;
    n_prs   = 1'b0;
    n_rls   = 1'b0;
    n_lng   = 1'b0;
    n_run   = (m_d2 != m_lvl) ? m_run + 1 : 0;
    if (n_run == N) begin
      n_run = 0;
      n_lvl = m_d2;
      n_prs = m_d2;
      n_rls = !m_d2;
      if (m_d2) begin
        n_tgl   = !m_tgl;
        n_since = 0;
        n_ldone = 1'b0;
      end
    end else if (m_lvl) begin
      if (m_since < L) n_since = m_since + 1;
      if (n_since == L && !m_ldone) begin
        n_lng   = 1'b1;
        n_ldone = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 <= 0; m_d2 <= 0; m_lvl <= 0; m_prs <= 0; m_rls <= 0;
      m_lng <= 0; m_tgl <= 0; m_ldone <= 0; m_run <= 0; m_since <= 0;
    end else begin
      m_d1 <= btn; m_d2 <= m_d1;
      m_lvl <= n_lvl; m_prs <= n_prs; m_rls <= n_rls; m_lng <= n_lng;
      m_tgl <= n_tgl; m_ldone <= n_ldone; m_run <= n_run; m_since <= n_since;
    end
  end

  wire [4:0] exp_vec = {m_lvl, m_prs, m_rls, m_lng, m_tgl};

  // Every-cycle comparison of both instances, plus event tallies.
  always @(negedge clk) begin
    check("cyc_hi", oh, exp_vec);
    check("cyc_lo", ol, exp_vec);
    if (h_press)   press_cnt++;
    if (h_release) release_cnt++;
    if (h_long)    long_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    btn = 1'b0;
    tick(3);
    check("reset_state", oh, 5'b00000);
    rst_n = 1'b1;
    tick(3);

    // Bounce: high for 3 edges, low for 3, three times.
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1; tick(3);
      btn = 1'b0; tick(3);
    end
    tick(4);
    check("bounce_outs", oh, 5'b00000);
    check("bounce_no_press", 5'(press_cnt), 5'd0);

    // Clean press, then long press while held.
    btn = 1'b1;
    tick(5);
    check("press_not_early", oh, 5'b00000);
    tick(1);
    check("press_edge", oh, 5'b11001);
    check("model_pin_press", exp_vec, 5'b11001);
    tick(1);
    check("press_one_cycle", oh, 5'b10001);
    tick(18);
    check("long_not_early", oh, 5'b10001);
    tick(1);
    check("long_edge", oh, 5'b10011);
    check("model_pin_long", exp_vec, 5'b10011);
    tick(1);
    check("long_one_cycle", oh, 5'b10001);
    tick(14);
    check("long_once", 5'(long_cnt), 5'd1);

    // Release.
    btn = 1'b0;
    tick(5);
    check("release_not_early", oh, 5'b10001);
    tick(1);
    check("release_edge", oh, 5'b00101);
    tick(1);
    check("release_one_cycle", oh, 5'b00001);

    // Second press toggles back to 0.
    tick(3);
    btn = 1'b1;
    tick(6);
    check("second_press", oh, 5'b11000);

    // Release glitch of 2 cycles; LONG timing unchanged.
    tick(3);
    btn = 1'b0; tick(2);
    btn = 1'b1; tick(14);
    check("glitch_level", oh, 5'b10000);
    tick(1);
    check("glitch_long_edge", oh, 5'b10010);
    check("glitch_no_press", 5'(press_cnt), 5'd2);
    check("glitch_no_release", 5'(release_cnt), 5'd1);
    btn = 1'b0;
    tick(10);
    check("glitch_then_release", 5'(release_cnt), 5'd2);

    // Release lands on the same edge LONG would fire: RELEASE wins.
    btn = 1'b1;
    tick(6);
    check("coincide_press", oh, 5'b11001);
    tick(14);
    btn = 1'b0;
    tick(5);
    check("coincide_before", oh, 5'b10001);
    tick(1);
    check("coincide_release", oh, 5'b00101);
    check("model_pin_coincide", exp_vec, 5'b00101);
    tick(3);
    check("coincide_no_long", 5'(long_cnt), 5'd2);

    // Reset during PRESS_CHK clears outputs at once; held button re-presses.
    tick(2);
    btn = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear_hi", oh, 5'b00000);
    check("async_clear_lo", ol, 5'b00000);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post_reset_quiet", oh, 5'b00000);
    tick(1);
    check("post_reset_press", oh, 5'b11001);
    check("post_reset_press_lo", ol, 5'b11001);
    tick(1);
    check("post_reset_hold", oh, 5'b10001);

    btn = 1'b0;
    tick(8);
    check("final_release", oh, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
